// File: rtl/hazard_int_ctrl_if.sv
// Control bus between the decode-stage hazard/interrupt controller and the
// rest of the RAT pipeline. The master drives the pipeline status (decode and
// execute fields, interrupt request). The slave is the controller, which
// returns the stall, flush, bubble and inject strobes.
interface hazard_int_ctrl_if #(
    parameter int ADDR_W = 5
);
    logic              intr_req;
    logic              i_en;
    logic [ADDR_W-1:0] id_addr_x;
    logic [ADDR_W-1:0] id_addr_y;
    logic              id_use_x;
    logic              id_use_y;
    logic [ADDR_W-1:0] ex_wb_addr;
    logic              ex_rf_wr;
    logic              ex_mem_rd;
    logic              ex_branch_taken;

    logic              pc_stall;
    logic              if_id_hold;
    logic              if_id_flush;
    logic              id_ex_nop;
    logic              int_inject;
    logic              int_ack;
    logic [15:0]       stall_count;

    modport master (
        output intr_req, i_en, id_addr_x, id_addr_y, id_use_x, id_use_y,
               ex_wb_addr, ex_rf_wr, ex_mem_rd, ex_branch_taken,
        input  pc_stall, if_id_hold, if_id_flush, id_ex_nop, int_inject,
               int_ack, stall_count
    );

    modport slave (
        input  intr_req, i_en, id_addr_x, id_addr_y, id_use_x, id_use_y,
               ex_wb_addr, ex_rf_wr, ex_mem_rd, ex_branch_taken,
        output pc_stall, if_id_hold, if_id_flush, id_ex_nop, int_inject,
               int_ack, stall_count
    );
endinterface

// File: rtl/hazard_int_ctrl.sv
// Hazard and interrupt-entry controller for the pipelined RAT CPU.
// Detects load-use hazards and taken-branch flushes, and sequences interrupt
// entry as: latch request -> drain -> inject -> flush wrong-path fetches.
// All strobes are decoded combinationally from state and inputs, and they are
// forced low while rst_n is asserted.
// Optional: define HAZARD_STATS_EN to build the saturating bubble counter
// behind stall_count. Without it, stall_count is tied to zero.
//
// Cycle counting:
//   FLUSH_CYCLES counts the triggering cycle. That cycle is the RUN cycle that
//   sees the branch, or the INT_FIRE cycle. FLUSH therefore lasts
//   FLUSH_CYCLES-1 cycles, and the state is skipped when that is zero.
//   DRAIN_CYCLES is the number of INT_DRAIN cycles. The RUN cycle that accepts
//   the interrupt stalls nothing, so the EX instruction can complete.
module hazard_int_ctrl #(
    parameter int ADDR_W       = 5,
    parameter int FLUSH_CYCLES = 2,
    parameter int DRAIN_CYCLES = 2
) (
    input logic             clk,
    input logic             rst_n,
    hazard_int_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        RUN       = 2'd0,
        FLUSH     = 2'd1,
        INT_DRAIN = 2'd2,
        INT_FIRE  = 2'd3
    } state_t;

    localparam logic [2:0] FLUSH_LD = 3'(FLUSH_CYCLES - 1);
    localparam logic [2:0] DRAIN_LD = 3'(DRAIN_CYCLES - 1);

    state_t     state, state_nxt;
    logic [2:0] cnt, cnt_nxt;
    logic       int_pend, int_pend_nxt;

    logic [ADDR_W-1:0] addr_x, addr_y, wb_addr;
    logic load_use;
    logic pc_stall_c, if_id_hold_c, if_id_flush_c, id_ex_nop_c;
    logic int_inject_c, int_ack_c;

    assign addr_x  = bus.id_addr_x;
    assign addr_y  = bus.id_addr_y;
    assign wb_addr = bus.ex_wb_addr;

    // A load in EX whose result a decode-stage source needs cannot be forwarded.
    assign load_use = bus.ex_rf_wr & bus.ex_mem_rd &
                      ((bus.id_use_x & (addr_x == wb_addr)) |
                       (bus.id_use_y & (addr_y == wb_addr)));

    // State, counter and pending-interrupt registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            cnt      <= 3'd0;
            int_pend <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            int_pend <= int_pend_nxt;
        end
    end

    // Pending latch. INT_FIRE consumes the request. Losing i_en before the
    // drain starts withdraws it. Once draining, the entry is committed.
    always_comb begin
        int_pend_nxt = int_pend;
        if (state == INT_FIRE)
            int_pend_nxt = 1'b0;
        else if (bus.intr_req && bus.i_en)
            int_pend_nxt = 1'b1;
        else if (!bus.i_en && (state == RUN || state == FLUSH))
            int_pend_nxt = 1'b0;
    end

    // Next-state and strobe decode.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        pc_stall_c    = 1'b0;
        if_id_hold_c  = 1'b0;
        if_id_flush_c = 1'b0;
        id_ex_nop_c   = 1'b0;
        int_inject_c  = 1'b0;
        int_ack_c     = 1'b0;
        case (state)
            RUN: begin
                if (bus.ex_branch_taken) begin
                    if_id_flush_c = 1'b1;
                    id_ex_nop_c   = 1'b1;
                    cnt_nxt       = FLUSH_LD;
                    state_nxt     = (FLUSH_LD != 3'd0) ? FLUSH : RUN;
                end else if (load_use) begin
                    // One bubble is enough: next cycle EX holds the NOP.
                    pc_stall_c   = 1'b1;
                    if_id_hold_c = 1'b1;
                    id_ex_nop_c  = 1'b1;
                end else if (int_pend && bus.i_en) begin
                    cnt_nxt   = DRAIN_LD;
                    state_nxt = INT_DRAIN;
                end
            end
            FLUSH: begin
                if_id_flush_c = 1'b1;
                id_ex_nop_c   = 1'b1;
                if (bus.ex_branch_taken) begin
                    cnt_nxt = FLUSH_LD;
                end else if (cnt <= 3'd1) begin
                    cnt_nxt   = 3'd0;
                    state_nxt = RUN;
                end else begin
                    cnt_nxt = cnt - 3'd1;
                end
            end
            INT_DRAIN: begin
                // A branch here still redirects the PC. The redirected target
                // becomes the interrupt return address.
                pc_stall_c    = 1'b1;
                if_id_flush_c = 1'b1;
                id_ex_nop_c   = 1'b1;
                if (cnt == 3'd0)
                    state_nxt = INT_FIRE;
                else
                    cnt_nxt = cnt - 3'd1;
            end
            INT_FIRE: begin
                int_inject_c  = 1'b1;
                int_ack_c     = 1'b1;
                pc_stall_c    = 1'b1;
                if_id_flush_c = 1'b1;
                cnt_nxt       = FLUSH_LD;
                state_nxt     = (FLUSH_LD != 3'd0) ? FLUSH : RUN;
            end
            default: state_nxt = RUN;
        endcase
    end

    assign bus.pc_stall    = rst_n & pc_stall_c;
    assign bus.if_id_hold  = rst_n & if_id_hold_c;
    assign bus.if_id_flush = rst_n & if_id_flush_c;
    assign bus.id_ex_nop   = rst_n & id_ex_nop_c;
    assign bus.int_inject  = rst_n & int_inject_c;
    assign bus.int_ack     = rst_n & int_ack_c;

`ifdef HAZARD_STATS_EN
    logic [15:0] stall_cnt;

    // Saturating count of cycles that put a bubble or interrupt into ID/EX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= 16'h0000;
        else if ((id_ex_nop_c | int_inject_c) && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'h0001;
    end

    assign bus.stall_count = stall_cnt;
`else
    assign bus.stall_count = 16'h0000;
`endif
endmodule

// File: tb/tb_hazard_int_ctrl.sv
// Self-checking bench for hazard_int_ctrl.
// The reference keeps a queue of scheduled pipeline actions ('D' drain,
// 'I' inject, 'F' flush). When the queue is empty, the pipeline runs normally
// and hazards are decoded from the inputs.
module tb_hazard_int_ctrl;
    localparam int ADDR_W = 5;
    localparam int FC     = 2;
    localparam int DC     = 2;
    localparam byte KD = 8'd68, KI = 8'd73, KF = 8'd70;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hazard_int_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    hazard_int_ctrl #(
        .ADDR_W(ADDR_W), .FLUSH_CYCLES(FC), .DRAIN_CYCLES(DC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model.
    byte         sched[$];
    bit          pend;
    int unsigned m_cnt;
    logic e_stall, e_hold, e_flush, e_nop, e_inj, e_ack;

    function automatic bit m_load_use();
        return bus.ex_rf_wr && bus.ex_mem_rd &&
               ((bus.id_use_x && bus.id_addr_x == bus.ex_wb_addr) ||
                (bus.id_use_y && bus.id_addr_y == bus.ex_wb_addr));
    endfunction

    task automatic model_eval();
        {e_stall, e_hold, e_flush, e_nop, e_inj, e_ack} = '0;
        if (rst_n) begin
            if (sched.size() == 0) begin
                if (bus.ex_branch_taken) begin
                    e_flush = 1; e_nop = 1;
                end else if (m_load_use()) begin
                    e_stall = 1; e_hold = 1; e_nop = 1;
                end
            end else if (sched[0] == KF) begin
                e_flush = 1; e_nop = 1;
            end else if (sched[0] == KD) begin
                e_stall = 1; e_flush = 1; e_nop = 1;
            end else begin
                e_inj = 1; e_ack = 1; e_stall = 1; e_flush = 1;
            end
        end
    endtask

    task automatic model_clock();
        byte head;
        bit  go_int;
        if (!rst_n) begin
            sched.delete(); pend = 0; m_cnt = 0;
        end else begin
            head   = (sched.size() == 0) ? 8'd0 : sched[0];
            go_int = (head == 0) && !bus.ex_branch_taken && !m_load_use() && pend && bus.i_en;
            if ((e_nop || e_inj) && m_cnt < 32'hFFFF) m_cnt++;
            if (head == KI) pend = 0;
            else if (bus.intr_req && bus.i_en) pend = 1;
            else if (!bus.i_en && (head == 0 || head == KF)) pend = 0;
            if (head == 0) begin
                if (bus.ex_branch_taken)
                    for (int i = 0; i < FC - 1; i++) sched.push_back(KF);
                else if (go_int) begin
                    for (int i = 0; i < DC; i++) sched.push_back(KD);
                    sched.push_back(KI);
                    for (int i = 0; i < FC - 1; i++) sched.push_back(KF);
                end
            end else begin
                void'(sched.pop_front());
                if (head == KF && bus.ex_branch_taken) begin
                    sched.delete();
                    for (int i = 0; i < FC - 1; i++) sched.push_back(KF);
                end
            end
        end
    endtask

    // One clock: check at negedge, advance the model at posedge, then return
    // just after the edge so that the caller can drive new inputs.
    task automatic cyc();
        @(negedge clk);
        model_eval();
        chk("pc_stall",    {31'd0, bus.pc_stall},    {31'd0, e_stall});
        chk("if_id_hold",  {31'd0, bus.if_id_hold},  {31'd0, e_hold});
        chk("if_id_flush", {31'd0, bus.if_id_flush}, {31'd0, e_flush});
        chk("id_ex_nop",   {31'd0, bus.id_ex_nop},   {31'd0, e_nop});
        chk("int_inject",  {31'd0, bus.int_inject},  {31'd0, e_inj});
        chk("int_ack",     {31'd0, bus.int_ack},     {31'd0, e_ack});
`ifdef HAZARD_STATS_EN
        chk("stall_count", {16'd0, bus.stall_count}, m_cnt);
`else
        chk("stall_count", {16'd0, bus.stall_count}, 32'd0);
`endif
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic idle_inputs();
        bus.intr_req = 0; bus.i_en = 0;
        bus.id_addr_x = '0; bus.id_addr_y = '0; bus.id_use_x = 0; bus.id_use_y = 0;
        bus.ex_wb_addr = '0; bus.ex_rf_wr = 0; bus.ex_mem_rd = 0; bus.ex_branch_taken = 0;
    endtask

    task automatic set_lu(input bit mem_rd);
        bus.ex_rf_wr = 1; bus.ex_mem_rd = mem_rd; bus.ex_wb_addr = 5'd3;
        bus.id_use_x = 1; bus.id_addr_x = 5'd3;
    endtask

    initial begin
        idle_inputs();
        cyc();                         // outputs held low in reset
        rst_n = 1;
        cyc(); cyc();

        // Load-use: one bubble, then clear; no stall without the memory read.
        set_lu(1); cyc();
        idle_inputs(); cyc();
        set_lu(0); cyc();
        idle_inputs(); cyc();

        // Taken branch alone, then branch colliding with load-use.
        bus.ex_branch_taken = 1; cyc();
        bus.ex_branch_taken = 0; repeat (3) cyc();
        set_lu(1); bus.ex_branch_taken = 1; cyc();
        idle_inputs(); repeat (3) cyc();

        // Interrupt entry, then a request while disabled.
        bus.intr_req = 1; bus.i_en = 1; cyc();
        bus.intr_req = 0; repeat (8) cyc();
        bus.i_en = 0; bus.intr_req = 1; repeat (4) cyc();
        idle_inputs(); cyc();

        // Asynchronous reset in the middle of the drain.
        bus.intr_req = 1; bus.i_en = 1; cyc();
        bus.intr_req = 0; cyc();
        cyc();                         // now inside INT_DRAIN
        bus.ex_branch_taken = 1;
        #1 rst_n = 0;
        #1;
        chk("rst_pc_stall",    {31'd0, bus.pc_stall},    32'd0);
        chk("rst_if_id_flush", {31'd0, bus.if_id_flush}, 32'd0);
        chk("rst_id_ex_nop",   {31'd0, bus.id_ex_nop},   32'd0);
        chk("rst_stall_count", {16'd0, bus.stall_count}, 32'd0);
        sched.delete(); pend = 0; m_cnt = 0;
        cyc();
        rst_n = 1; idle_inputs(); bus.i_en = 1;
        repeat (4) cyc();              // no leftover interrupt after reset

        // Randomised traffic.
        for (int n = 0; n < 3000; n++) begin
            bus.ex_branch_taken = ($urandom_range(0, 9) == 0);
            bus.intr_req   = ($urandom_range(0, 19) == 0);
            bus.i_en       = ($urandom_range(0, 7) != 0);
            bus.ex_rf_wr   = $urandom_range(0, 1);
            bus.ex_mem_rd  = $urandom_range(0, 1);
            bus.ex_wb_addr = 5'($urandom_range(0, 3));
            bus.id_addr_x  = 5'($urandom_range(0, 3));
            bus.id_addr_y  = 5'($urandom_range(0, 3));
            bus.id_use_x   = $urandom_range(0, 1);
            bus.id_use_y   = $urandom_range(0, 1);
            cyc();
        end
        idle_inputs(); repeat (10) cyc();

`ifdef HAZARD_STATS_EN
        // Saturation: a long run of forced bubbles.
        set_lu(1);
        repeat (65540) cyc();
        idle_inputs(); cyc();
        chk("stall_count_sat", {16'd0, bus.stall_count}, 32'h0000FFFF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
